mul_div_unit: RTL and testbench

//  Multi-cycle multiply/divide engine consuming the 5-bit ALU control code from the ALU control

---
 rtl/mul_div_unit.sv | 192 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide engine owning the architectural HI/LO registers.
// Radix-2 datapath: shift-add multiply and restoring divide, one step per clock,
// operating on operand magnitudes with a final sign-correction cycle.
module mul_div_unit #(
    parameter int         WIDTH    = 32,
    parameter logic [4:0] OP_MULT  = 5'b01111,
    parameter logic [4:0] OP_MULTU = 5'b10000,
    parameter logic [4:0] OP_DIV   = 5'b10001,
    parameter logic [4:0] OP_DIVU  = 5'b10010
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       alu_ctrl_in,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             div0_q, div0_d;
    logic             neg_res_q, neg_res_d;   // product / quotient must be negated
    logic             neg_rem_q, neg_rem_d;   // remainder takes dividend's sign
    logic [WIDTH-1:0] mcand_q, mcand_d;       // multiplicand or divisor magnitude
    logic [WIDTH:0]   acc_q, acc_d;           // product high half / partial remainder
    logic [WIDTH-1:0] q_q, q_d;               // multiplier bits out / quotient bits in
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Decode of the incoming request
    logic             code_valid;
    logic             code_signed;
    logic             code_div;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign code_valid  = (alu_ctrl_in == OP_MULT) || (alu_ctrl_in == OP_MULTU) ||
                         (alu_ctrl_in == OP_DIV)  || (alu_ctrl_in == OP_DIVU);
    assign code_signed = (alu_ctrl_in == OP_MULT) || (alu_ctrl_in == OP_DIV);
    assign code_div    = (alu_ctrl_in == OP_DIV)  || (alu_ctrl_in == OP_DIVU);
    assign a_neg       = code_signed & op_a[WIDTH-1];
    assign b_neg       = code_signed & op_b[WIDTH-1];
    assign mag_a       = a_neg ? (~op_a + 1'b1) : op_a;
    assign mag_b       = b_neg ? (~op_b + 1'b1) : op_b;

    // One radix-2 step of each algorithm
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   mul_acc_nxt;
    logic [WIDTH-1:0] mul_q_nxt;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   div_acc_nxt;
    logic [WIDTH-1:0] div_q_nxt;

    assign mul_sum     = acc_q + (q_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_acc_nxt = {1'b0, mul_sum[WIDTH:1]};
    assign mul_q_nxt   = {mul_sum[0], q_q[WIDTH-1:1]};

    // Restoring divide: keep the subtraction only when it did not borrow
    assign rem_sh      = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign trial       = rem_sh - {1'b0, mcand_q};
    assign div_acc_nxt = trial[WIDTH] ? rem_sh : trial;
    assign div_q_nxt   = {q_q[WIDTH-2:0], ~trial[WIDTH]};

    // Sign correction applied in the final cycle
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign product  = {acc_q[WIDTH-1:0], q_q};
    assign prod_fix = neg_res_q ? (~product + 1'b1) : product;
    assign quot_fix = neg_res_q ? (~q_q + 1'b1) : q_q;
    assign rem_fix  = neg_rem_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];

    // Next-state logic for the controller and datapath
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        q_d       = q_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start && code_valid) begin
                    is_div_d  = code_div;
                    div0_d    = code_div && (op_b == '0);
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    acc_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_CALC;
                    if (code_div) begin
                        mcand_d = mag_b;
                        q_d     = mag_a;
                    end else begin
                        mcand_d = mag_a;
                        q_d     = mag_b;
                    end
                end
            end
            ST_CALC: begin
                acc_d = is_div_q ? div_acc_nxt : mul_acc_nxt;
                q_d   = is_div_q ? div_q_nxt   : mul_q_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_div_q) begin
                    // With a zero divisor the partial remainder has collected the
                    // dividend magnitude, so rem_fix reproduces op_a exactly.
                    hi_d = rem_fix;
                    lo_d = div0_q ? '1 : quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            div0_q    <= div0_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed plus randomized checks of mul_div_unit against an arithmetic reference.
module tb_mul_div_unit;

    localparam logic [4:0] OP_MULT  = 5'b01111;
    localparam logic [4:0] OP_MULTU = 5'b10000;
    localparam logic [4:0] OP_DIV   = 5'b10001;
    localparam logic [4:0] OP_DIVU  = 5'b10010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  alu_ctrl_in;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_hi = 32'h0;
    logic [31:0] model_lo = 32'h0;

    mul_div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_ctrl_in (alu_ctrl_in),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] ref_res(input logic [4:0] code, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sp;
        int     sq, sr;
        logic [63:0] r;
        r = '0;
        if (code == OP_MULTU) begin
            r = {32'h0, a} * {32'h0, b};
        end else if (code == OP_MULT) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            r  = sp;
        end else if (b == 32'h0) begin
            r = {a, 32'hFFFF_FFFF};
        end else if (code == OP_DIVU) begin
            r = {a % b, a / b};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = {32'h0, 32'h8000_0000};
        end else begin
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            r  = {sr, sq};
        end
        return r;
    endfunction

    // One operation: start, stray start and HI/LO writes mid-flight, then result checks
    task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                          input bit wr_at_start, input string tag);
        logic [63:0] exp;
        int n;
        int bc;
        exp = ref_res(code, a, b);
        @(negedge clk);
        alu_ctrl_in = code; op_a = a; op_b = b; start = 1'b1;
        if (wr_at_start) begin
            hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
            model_hi = 32'h0BAD_F00D; model_lo = 32'h0BAD_F00D;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op_a = $urandom; op_b = $urandom;
        check({tag, " busy_after_start"}, {63'h0, busy}, 64'h1);
        n = 0; bc = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) bc++;
            hi_we = (n == 3); lo_we = (n == 3); wdata = $urandom;
            start = (n == 4);
            if (n == 4) alu_ctrl_in = OP_DIVU;
            if (n == 6) begin
                check({tag, " hi_hold"}, {32'h0, hi}, {32'h0, model_hi});
                check({tag, " lo_hold"}, {32'h0, lo}, {32'h0, model_lo});
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
        check({tag, " latency"}, 64'(n), 64'd33);
        check({tag, " busy_cycles"}, 64'(bc), 64'd33);
        check({tag, " hi"}, {32'h0, hi}, {32'h0, exp[63:32]});
        check({tag, " lo"}, {32'h0, lo}, {32'h0, exp[31:0]});
        check({tag, " busy_end"}, {63'h0, busy}, 64'h0);
        model_hi = exp[63:32];
        model_lo = exp[31:0];
        @(negedge clk);
        check({tag, " done_pulse"}, {63'h0, done}, 64'h0);
        $display("op %s code=%b a=%h b=%h -> hi=%h lo=%h latency=%0d", tag, code, a, b, hi, lo, n);
    endtask

    logic [4:0]  codes [4];
    logic [4:0]  rc;
    logic [31:0] ra, rb;
    int          dcount;

    initial begin
        codes[0] = OP_MULT; codes[1] = OP_MULTU; codes[2] = OP_DIV; codes[3] = OP_DIVU;
        rst_n = 1'b0; alu_ctrl_in = '0; start = 1'b0; op_a = '0; op_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {63'h0, busy}, 64'h0);
        check("reset done", {63'h0, done}, 64'h0);
        check("reset hi", {32'h0, hi}, 64'h0);
        check("reset lo", {32'h0, lo}, 64'h0);
        rst_n = 1'b1;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         1'b0, "mult_neg");
        run_op(OP_MULTU, 32'hFFFF_FFFD, 32'd5,         1'b0, "multu_bits");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, "div_neg");
        run_op(OP_DIVU,  32'd7,         32'd2,         1'b0, "divu_7_2");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_op(OP_DIV,   32'd123,       32'd0,         1'b0, "div_zero");
        run_op(OP_MULTU, 32'd2,         32'd3,         1'b1, "multu_2_3");
        run_op(OP_DIV,   32'hFFFF_FF85, 32'd0,         1'b0, "div_zero_neg");

        // mthi in IDLE takes effect on the next edge
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        @(negedge clk);
        hi_we = 1'b0;
        model_hi = 32'hA5A5_A5A5;
        check("mthi hi", {32'h0, hi}, {32'h0, model_hi});
        check("mthi lo", {32'h0, lo}, {32'h0, model_lo});
        $display("mthi wdata=A5A5A5A5 -> hi=%h", hi);

        // Non mul/div code is ignored
        alu_ctrl_in = 5'b00010; start = 1'b1; op_a = 32'd9; op_b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("bad_code busy", {63'h0, busy}, 64'h0);
        check("bad_code hi", {32'h0, hi}, {32'h0, model_hi});
        $display("start code=00010 -> busy=%b", busy);

        // Reset in the middle of CALC
        alu_ctrl_in = OP_MULTU; start = 1'b1; op_a = 32'd1000; op_b = 32'd1000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", {63'h0, busy}, 64'h0);
        check("abort hi", {32'h0, hi}, 64'h0);
        check("abort lo", {32'h0, lo}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_hi = 32'h0; model_lo = 32'h0;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("abort no_done", 64'(dcount), 64'd0);
        check("abort hi_after", {32'h0, hi}, 64'h0);
        $display("reset mid-op -> busy=%b hi=%h lo=%h done_pulses=%0d", busy, hi, lo, dcount);

        // Randomized operations against the reference
        for (int i = 0; i < 12; i++) begin
            rc = codes[$urandom_range(3)];
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(1) == 1) rb = rb >> $urandom_range(31);
            if ($urandom_range(7) == 0) rb = 32'h0;
            run_op(rc, ra, rb, ($urandom_range(3) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
